// File: rtl/char_stream_sequencer.sv
// Walks a LEN-position index and streams MSG characters as 7-bit ASCII over valid/ready.
// Configurable step divider, direction, wrap/stop and back-pressure.
module char_stream_sequencer #(
    parameter int unsigned LEN = 14,
    parameter logic [8*LEN-1:0] MSG = "ABCDEFGHIJKLMN",
    parameter int unsigned DIV = 1,
    localparam int unsigned IW = $clog2(LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          en,
    input  logic          dir,
    input  logic          wrap,
    input  logic          ready,
    output logic          valid,
    output logic [6:0]    ascii,
    output logic [IW-1:0] idx,
    output logic [LEN-1:0] pos_onehot,
    output logic          busy,
    output logic          done
);

    localparam int unsigned DW = $clog2(DIV + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
    localparam logic [DW-1:0] DIV_TOP  = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHOW,
        S_DONE
    } state_t;

    state_t        state;
    logic          dir_q;
    logic [DW-1:0] div_q;

    logic          is_last_c;
    logic [IW-1:0] first_c;
    logic [IW-1:0] start_idx_c;
    logic [IW-1:0] next_c;

    // Byte at position i, position 0 being the most-significant byte of MSG.
    function automatic logic [6:0] char_at(input logic [IW-1:0] i);
        int unsigned base;
        base = 8 * (LEN - 1 - 32'(i));
        return MSG[base +: 7];
    endfunction

    function automatic logic [LEN-1:0] onehot(input logic [IW-1:0] i);
        return LEN'(1) << i;
    endfunction

    // Index stepping helpers; the end-of-run test keeps idx inside 0..LEN-1.
    always_comb begin
        first_c     = dir_q ? LAST_IDX : '0;
        start_idx_c = dir   ? LAST_IDX : '0;
        is_last_c   = dir_q ? (idx == '0) : (idx == LAST_IDX);
        next_c      = dir_q ? (idx - IW'(1)) : (idx + IW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dir_q      <= 1'b0;
            div_q      <= '0;
            idx        <= '0;
            pos_onehot <= LEN'(1);
            ascii      <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (start) begin
            // Start wins over any same-cycle handshake; idx reloads instead of stepping.
            state      <= S_WAIT;
            dir_q      <= dir;
            div_q      <= '0;
            idx        <= start_idx_c;
            pos_onehot <= onehot(start_idx_c);
            valid      <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (en) begin
                        if (div_q == DIV_TOP) begin
                            div_q <= '0;
                            ascii <= char_at(idx);
                            valid <= 1'b1;
                            state <= S_SHOW;
                        end else begin
                            div_q <= div_q + DW'(1);
                        end
                    end
                end
                S_SHOW: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (!is_last_c) begin
                            idx        <= next_c;
                            pos_onehot <= onehot(next_c);
                            state      <= S_WAIT;
                        end else if (wrap) begin
                            idx        <= first_c;
                            pos_onehot <= onehot(first_c);
                            state      <= S_WAIT;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/char_stream_sequencer.md
# char_stream_sequencer

Parametrised character sequencer that walks a LEN-position index counter and streams the character stored at each position as 7-bit ASCII over a valid/ready handshake. It generalises the fixed 14-stage counter plus name encoder into one configurable block. The generalisations are message length and contents, a programmable step rate, up/down direction, wrap or stop-at-end, and back-pressure. It sits between a free-running system clock and any character consumer (display driver, UART TX, testbench monitor).

## Interface
- LEN, 14, number of characters/positions; LEN ≥ 2
- MSG, "ABCDEFGHIJKLMN", 8*LEN-bit packed string; position 0 = most-significant byte (Verilog string order)
- DIV, 1, enabled clock cycles spent in WAIT before each character is presented; DIV ≥ 1
- IW (localparam), $clog2(LEN), index width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse: load first index and begin streaming
- en  input  1  step-rate enable; gates the WAIT divider only
- dir  input  1  0 = up (0→LEN-1), 1 = down (LEN-1→0); latched on start
- wrap  input  1  1 = restart after last character, 0 = stop; sampled at last handshake
- ready  input  1  consumer accepts character
- valid  output  1  ascii holds a character for the consumer
- ascii  output  7  MSG byte at current index, bits [6:0]
- idx  output  IW  current position
- pos_onehot  output  LEN  1 << idx
- busy  output  1  state is WAIT or SHOW
- done  output  1  sequence finished (non-wrap); level until next start

## Operation
- States: IDLE, WAIT, SHOW, DONE.
- Reset, asynchronous, takes effect immediately, including mid-operation. State = IDLE, idx = 0, pos_onehot = 1, ascii = 0, valid = 0, busy = 0, done = 0, divider = 0, latched dir = 0.
- start, in any state: latch dir. idx ← 0 (up) or LEN-1 (down). Divider ← 0, valid ← 0, done ← 0, state ← WAIT.
- start has priority over every other event, including a valid&&ready handshake in the same cycle. The handshake still counts as a completed transfer on the bus, but idx does not advance from it.
- WAIT:
  - Divider increments only on cycles with en = 1. en = 0 freezes the divider.
  - When divider == DIV-1 and en = 1: divider ← 0, ascii ← MSG[8*(LEN-1-idx) +: 7], valid ← 1, state ← SHOW.
- SHOW:
  - valid stays high and ascii stays stable until ready. en is ignored.
  - Handshake = valid && ready at a rising edge. On handshake valid ← 0, then:
  - Not last index: idx ← idx+1 (up) or idx-1 (down); state ← WAIT.
  - Last index (LEN-1 up / 0 down) with wrap = 1: idx ← first index (0 up / LEN-1 down); state ← WAIT.
  - Last index with wrap = 0: idx holds; state ← DONE, done ← 1.
- DONE: all outputs hold (valid = 0, done = 1) until start or reset.
- IDLE: outputs hold their reset values; only start leaves IDLE.
- Arithmetic:
  - idx never leaves 0..LEN-1, including when LEN is not a power of two.
  - The divider is $clog2(DIV+1) bits wide and never exceeds DIV-1.
- pos_onehot is derived from idx and is exactly one-hot at all times.

## Timing
- All state updates on the rising clk edge except reset.
- Start sampled at edge k with en held high: valid rises after edge k+DIV, ascii valid from the same edge.
- Handshake at edge m with en held high: valid low after m, next valid rises after edge m+DIV. valid therefore never stays high across two consecutive characters; minimum gap is DIV cycles.
- With ready tied high and en high, one character every DIV+1 cycles.
- idx and pos_onehot update at the handshake edge. They are one position ahead of ascii during the following WAIT.
- done rises at the edge of the final handshake. busy falls at the same edge.

## Test plan
- Up, no wrap: LEN=14, DIV=1, ready=1, en=1, dir=0, wrap=0, start at cycle 2. Required:
  - valid every 2 cycles.
  - ascii sequence 'A','B',…,'N' (0x41..0x4E).
  - done=1 after the 14th handshake; idx=13, pos_onehot=14'h2000.
- Down, wrap: dir=1, wrap=1. Required:
  - Sequence 'N'..'A', then 'N' again.
  - done never asserts; busy stays 1.
- Back-pressure and en: DIV=3, ready low for 5 cycles during SHOW, en toggled 1/0 during WAIT. Required:
  - ascii and valid stable throughout the stall.
  - WAIT lasts exactly 3 en-high cycles.
- Restart collision: start asserted in the same cycle as a handshake on 'E' (idx=4, up). Required: idx=0 next cycle, 'F' never emitted, next character 'A'.
- Reset mid-stream: rst_n low between edges while valid=1, idx=7. Required: valid, ascii, busy and done drop to 0 and idx to 0 immediately, before the next edge, and stay there until start.
- Non-power-of-two: LEN=5, MSG="HELLO", wrap=1, up. Required: stream H,E,L,L,O,H,…; idx never reaches 5–7.
